quad_decoder_channel: RTL

//  Front-end for one differential quadrature encoder channel, upstream of the myoquad Avalon slave.

---
 rtl/quad_decoder_channel.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/quad_decoder_channel.sv
// Front end for one differential quadrature encoder channel.
// It synchronises and line-checks the pins, deglitches A/B and decodes them in 4x mode into a
// position count. It also produces a windowed velocity, error/fault status and a snapshot
// handshake.
module quad_decoder_channel #(
  parameter int unsigned POS_W         = 32,
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned SAMPLE_PERIOD = 500000,
  parameter bit          INVERT_DIR    = 1'b0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_apos,
  input  logic             i_aneg,
  input  logic             i_bpos,
  input  logic             i_bneg,
  input  logic             i_zero_req,
  input  logic             i_fault_clear,
  input  logic             i_snap_req,
  output logic             o_snap_ack,
  output logic [POS_W-1:0] o_snap_pos,
  output logic [POS_W-1:0] o_snap_vel,
  output logic [POS_W-1:0] o_position,
  output logic [POS_W-1:0] o_velocity,
  output logic             o_vel_valid,
  output logic [1:0]       o_line_fault,
  output logic [15:0]      o_err_count
);

  localparam int unsigned    FCW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned    WCW       = $clog2(SAMPLE_PERIOD);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WCW-1:0] WIN_LAST  = WCW'(SAMPLE_PERIOD - 1);

  logic [3:0]          r_sync1, r_sync2;
  logic [1:0]          w_pin, w_fault;      // index 0 = channel A, 1 = channel B
  logic [1:0]          r_filt, w_filt_d;
  logic [1:0][FCW-1:0] r_fcnt, w_fcnt_d;
  logic [1:0]          r_ab_prev, w_ab_cur, w_diff;
  logic                w_up, w_dn, w_illegal;
  logic [POS_W-1:0]    r_position, w_position_d;
  logic [POS_W-1:0]    r_velocity, w_velocity_d;
  logic [POS_W-1:0]    r_baseline, w_baseline_d, w_base_eff;
  logic [WCW-1:0]      r_win, w_win_d;
  logic                w_tc;
  logic [15:0]         r_err, w_err_d, w_err_base;
  logic [1:0]          r_line_fault, w_line_fault_d;
  logic                r_vel_valid, r_snap_ack;
  logic [POS_W-1:0]    r_snap_pos, r_snap_vel;

  // Position of {A,B} within the forward cycle 00 -> 10 -> 11 -> 01
  function automatic logic [1:0] seq_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // Two-stage pin synchroniser; left unreset so reset can seed the filters from live pins
  always_ff @(posedge i_clock) begin
    r_sync1 <= {i_apos, i_aneg, i_bpos, i_bneg};
    r_sync2 <= r_sync1;
  end

  assign w_pin   = {r_sync2[1], r_sync2[3]};
  assign w_fault = {r_sync2[1] == r_sync2[0], r_sync2[3] == r_sync2[2]};

  // Deglitch: accept a new level after FILTER_LEN consecutive differing cycles; freeze on fault
  always_comb begin
    w_filt_d = r_filt;
    w_fcnt_d = r_fcnt;
    for (int ch = 0; ch < 2; ch++) begin
      if (!w_fault[ch]) begin
        if (w_pin[ch] != r_filt[ch]) begin
          if (r_fcnt[ch] == FCNT_LAST) begin
            w_filt_d[ch] = w_pin[ch];
            w_fcnt_d[ch] = '0;
          end else begin
            w_fcnt_d[ch] = r_fcnt[ch] + 1'b1;
          end
        end else begin
          w_fcnt_d[ch] = '0;
        end
      end
    end
  end

  // Step decode compares the registered filtered state with its previous value
  assign w_ab_cur  = {r_filt[0], r_filt[1]};
  assign w_diff    = seq_idx(w_ab_cur) - seq_idx(r_ab_prev);
  assign w_illegal = (w_diff == 2'd2);
  assign w_up      = INVERT_DIR ? (w_diff == 2'd3) : (w_diff == 2'd1);
  assign w_dn      = INVERT_DIR ? (w_diff == 2'd1) : (w_diff == 2'd3);

  // Position, velocity window and baseline next state; zero_req beats a coincident step
  always_comb begin
    w_position_d = r_position;
    if (i_zero_req) begin
      w_position_d = '0;
    end else if (w_up) begin
      w_position_d = r_position + POS_W'(1);
    end else if (w_dn) begin
      w_position_d = r_position - POS_W'(1);
    end
    w_tc         = (r_win == WIN_LAST);
    w_win_d      = w_tc ? '0 : r_win + 1'b1;
    w_base_eff   = i_zero_req ? '0 : r_baseline;
    w_velocity_d = r_velocity;
    w_baseline_d = w_base_eff;
    if (w_tc) begin
      // Modular difference stays correct across position wrap
      w_velocity_d = w_position_d - w_base_eff;
      w_baseline_d = w_position_d;
    end
  end

  // Error counter and sticky line faults; a live fault or illegal step outranks fault_clear
  always_comb begin
    w_err_base = i_fault_clear ? 16'd0 : r_err;
    w_err_d    = w_err_base;
    if (w_illegal && (w_err_base != 16'hFFFF)) begin
      w_err_d = w_err_base + 16'd1;
    end
    w_line_fault_d = (i_fault_clear ? 2'b00 : r_line_fault) | w_fault;
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_filt       <= w_pin;
      r_fcnt       <= '0;
      r_ab_prev    <= {w_pin[0], w_pin[1]};
      r_position   <= '0;
      r_velocity   <= '0;
      r_baseline   <= '0;
      r_win        <= '0;
      r_err        <= '0;
      r_line_fault <= '0;
      r_vel_valid  <= 1'b0;
      r_snap_ack   <= 1'b0;
      r_snap_pos   <= '0;
      r_snap_vel   <= '0;
    end else begin
      r_filt       <= w_filt_d;
      r_fcnt       <= w_fcnt_d;
      r_ab_prev    <= w_ab_cur;
      r_position   <= w_position_d;
      r_velocity   <= w_velocity_d;
      r_baseline   <= w_baseline_d;
      r_win        <= w_win_d;
      r_err        <= w_err_d;
      r_line_fault <= w_line_fault_d;
      r_vel_valid  <= w_tc;
      r_snap_ack   <= i_snap_req;
      if (i_snap_req) begin
        r_snap_pos <= w_position_d;
        r_snap_vel <= w_velocity_d;
      end
    end
  end

  assign o_snap_ack   = r_snap_ack;
  assign o_snap_pos   = r_snap_pos;
  assign o_snap_vel   = r_snap_vel;
  assign o_position   = r_position;
  assign o_velocity   = r_velocity;
  assign o_vel_valid  = r_vel_valid;
  assign o_line_fault = r_line_fault;
  assign o_err_count  = r_err;

endmodule
